microwave_cook_controller: RTL and testbench

- Sequencing controller for the magnetron path.
- Accepts keypad time entry as four BCD digits (mm:ss) and start/stop/clear presses, and monitors the door.
- Counts the cook time down and drives the magnetron enable and a completion pulse.
- Sits above the magnetron set/reset logic: its `mag_on` output feeds the magnetron driver, and its BCD digits feed the display decoder.

---
 rtl/microwave_cook_controller.sv | 236 +++++++++++++++++++++++
 tb/tb_microwave_cook_controller.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/microwave_cook_controller.sv
// ---------------------------------------------------------------------------
// microwave_cook_controller
//
// Sequencing controller for the magnetron path. It collects a four-digit BCD
// cook time (mm:ss) from the keypad, watches the start/stop/clear keys and
// the door, counts the time down, and drives the magnetron enable plus a
// one-cycle completion pulse.
//
// Optional feature: define MICROWAVE_DONE_BEEP_EN to build the completion
// beep counter. Without it, beep is tied to 0.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   startn       in   start key, active low (debounced, synchronous)
//   stopn        in   stop key, active low (debounced, synchronous)
//   clearn       in   clear key, active low (debounced, synchronous)
//   door_closed  in   1 = door closed
//   key_valid    in   strobe qualifying key_digit
//   key_digit    in   [3:0] keypad digit
//   mag_on       out  magnetron enable (COOKING and door closed)
//   done         out  one-cycle pulse when the countdown completes
//   state        out  [1:0] FSM state: 00 IDLE, 01 COOKING, 10 PAUSED, 11 DONE
//   min_tens, min_ones, sec_tens, sec_ones  out  [3:0] BCD remaining time
//   beep         out  completion beep
//
// Handshake: key_valid is a one-cycle strobe with no back-pressure; a digit
// is consumed on the clock edge where key_valid = 1 if the FSM is in IDLE and
// no higher-priority key event occurs in that cycle, otherwise it is dropped.
// ---------------------------------------------------------------------------
module microwave_cook_controller #(
    parameter int TICKS_PER_SEC = 100,
    parameter int BEEP_CYCLES   = 300
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       startn,
    input  logic       stopn,
    input  logic       clearn,
    input  logic       door_closed,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    output logic       mag_on,
    output logic       done,
    output logic [1:0] state,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       beep
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_COOKING = 2'b01,
        S_PAUSED  = 2'b10,
        S_DONE    = 2'b11
    } state_t;

    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICKS_PER_SEC - 1);

    state_t        state_q;
    logic [PW-1:0] pre_q;
    logic          start_q, stop_q, clear_q;

    // Press = registered level was released (1) and current level is low.
    logic start_ev, stop_ev, clear_ev, any_press;
    assign start_ev  = start_q & ~startn;
    assign stop_ev   = stop_q  & ~stopn;
    assign clear_ev  = clear_q & ~clearn;
    assign any_press = start_ev | stop_ev | clear_ev;

    logic time_zero;
    assign time_zero = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                       (sec_tens == 4'd0) && (sec_ones == 4'd0);

    logic tick;
    assign tick = (pre_q == PRE_MAX);

    // Time minus one second, BCD with borrow. Seconds tens borrows to 5.
    logic [3:0] dec_mt, dec_mo, dec_st, dec_so;
    always_comb begin
        dec_mt = min_tens;
        dec_mo = min_ones;
        dec_st = sec_tens;
        dec_so = sec_ones;
        if (sec_ones != 4'd0) begin
            dec_so = sec_ones - 4'd1;
        end else begin
            dec_so = 4'd9;
            if (sec_tens != 4'd0) begin
                dec_st = sec_tens - 4'd1;
            end else begin
                dec_st = 4'd5;
                if (min_ones != 4'd0) begin
                    dec_mo = min_ones - 4'd1;
                end else begin
                    dec_mo = 4'd9;
                    dec_mt = min_tens - 4'd1;
                end
            end
        end
    end

    logic dec_zero;
    assign dec_zero = (dec_mt == 4'd0) && (dec_mo == 4'd0) &&
                      (dec_st == 4'd0) && (dec_so == 4'd0);

    // Entry into DONE: either the countdown reaches zero while cooking
    // undisturbed, or a resume from PAUSED finds the time already at zero
    // (door opened on the final decrement).
    logic go_done;
    assign go_done = (!clear_ev && !stop_ev && door_closed) &&
                     (((state_q == S_COOKING) && tick && dec_zero) ||
                      ((state_q == S_PAUSED) && start_ev && time_zero));

    assign mag_on = (state_q == S_COOKING) && door_closed;
    assign state  = state_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pre_q    <= '0;
            start_q  <= 1'b1;
            stop_q   <= 1'b1;
            clear_q  <= 1'b1;
            done     <= 1'b0;
            min_tens <= 4'd0;
            min_ones <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
        end else begin
            start_q <= startn;
            stop_q  <= stopn;
            clear_q <= clearn;
            done    <= go_done;
            case (state_q)
                S_IDLE: begin
                    if (clear_ev) begin
                        min_tens <= 4'd0;
                        min_ones <= 4'd0;
                        sec_tens <= 4'd0;
                        sec_ones <= 4'd0;
                    end else if (stop_ev) begin
                        // stop has no action in IDLE but still outranks start/digits
                    end else if (start_ev) begin
                        if (door_closed && !time_zero) begin
                            state_q <= S_COOKING;
                            pre_q   <= '0;
                        end
                    end else if (key_valid && (key_digit <= 4'd9)) begin
                        min_tens <= min_ones;
                        min_ones <= sec_tens;
                        sec_tens <= sec_ones;
                        sec_ones <= key_digit;
                    end
                end
                S_COOKING: begin
                    // The cooking cycle always advances the countdown; the
                    // state decision below only selects where it lands. This
                    // is what lets a door-open on the last tick show 00:00.
                    pre_q <= tick ? '0 : pre_q + PW'(1);
                    if (tick) begin
                        min_tens <= dec_mt;
                        min_ones <= dec_mo;
                        sec_tens <= dec_st;
                        sec_ones <= dec_so;
                    end
                    if (clear_ev) begin
                        state_q  <= S_IDLE;
                        min_tens <= 4'd0;
                        min_ones <= 4'd0;
                        sec_tens <= 4'd0;
                        sec_ones <= 4'd0;
                    end else if (stop_ev || !door_closed) begin
                        state_q <= S_PAUSED;
                    end else if (go_done) begin
                        state_q <= S_DONE;
                    end
                end
                S_PAUSED: begin
                    if (clear_ev) begin
                        state_q  <= S_IDLE;
                        min_tens <= 4'd0;
                        min_ones <= 4'd0;
                        sec_tens <= 4'd0;
                        sec_ones <= 4'd0;
                    end else if (stop_ev) begin
                        state_q <= S_IDLE;
                    end else if (start_ev && door_closed) begin
                        state_q <= time_zero ? S_DONE : S_COOKING;
                    end
                end
                S_DONE: begin
                    if (any_press || !door_closed) begin
                        state_q <= S_IDLE;
                    end
                    if (clear_ev) begin
                        min_tens <= 4'd0;
                        min_ones <= 4'd0;
                        sec_tens <= 4'd0;
                        sec_ones <= 4'd0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef MICROWAVE_DONE_BEEP_EN
    localparam int BW = $clog2(BEEP_CYCLES + 1);

    logic [BW-1:0] beep_cnt;

    // beep_cnt holds the number of high cycles still owed after the current one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            beep     <= 1'b0;
            beep_cnt <= '0;
        end else if (go_done) begin
            beep     <= 1'b1;
            beep_cnt <= BW'(BEEP_CYCLES - 1);
        end else if (beep) begin
            if (any_press || !door_closed || (beep_cnt == '0)) begin
                beep <= 1'b0;
            end else begin
                beep_cnt <= beep_cnt - BW'(1);
            end
        end
    end
`else
    assign beep = 1'b0;
`endif

endmodule

// File: tb/tb_microwave_cook_controller.sv
module tb_microwave_cook_controller;

    localparam int TPS  = 4;
    localparam int BEEP = 5;

    logic       clock, reset;
    logic       startn, stopn, clearn, door_closed, key_valid;
    logic [3:0] key_digit;
    logic       mag_on, done, beep;
    logic [1:0] state;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 0;

    microwave_cook_controller #(.TICKS_PER_SEC(TPS), .BEEP_CYCLES(BEEP)) dut (
        .clock(clock), .reset(reset),
        .startn(startn), .stopn(stopn), .clearn(clearn),
        .door_closed(door_closed), .key_valid(key_valid), .key_digit(key_digit),
        .mag_on(mag_on), .done(done), .state(state),
        .min_tens(min_tens), .min_ones(min_ones),
        .sec_tens(sec_tens), .sec_ones(sec_ones),
        .beep(beep)
    );

    // ---------------- clock ----------------
    initial clock = 0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Time kept as integer minutes (0..99) and seconds (0..99).
    int m_st, m_min, m_sec, m_pre, m_beep_left;
    bit m_done, p_start, p_stop, p_clear;

    function automatic logic [15:0] m_digits();
        return {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)};
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_st = 0; m_min = 0; m_sec = 0; m_pre = 0; m_done = 0;
            m_beep_left = 0; p_start = 1; p_stop = 1; p_clear = 1;
        end else begin
            bit st_e, sp_e, cl_e, any_e, t;
            st_e  = p_start && !startn;
            sp_e  = p_stop && !stopn;
            cl_e  = p_clear && !clearn;
            any_e = st_e || sp_e || cl_e;
            m_done = 0;
            case (m_st)
                0: begin
                    if (cl_e) begin m_min = 0; m_sec = 0; end
                    else if (sp_e) ;
                    else if (st_e) begin
                        if (door_closed && (m_min + m_sec) != 0) begin m_st = 1; m_pre = 0; end
                    end else if (key_valid && key_digit <= 9) begin
                        m_min = (m_min % 10) * 10 + m_sec / 10;
                        m_sec = (m_sec % 10) * 10 + int'(key_digit);
                    end
                end
                1: begin
                    t = (m_pre == TPS - 1);
                    m_pre = t ? 0 : m_pre + 1;
                    if (t) begin
                        if (m_sec > 0) m_sec = m_sec - 1;
                        else begin m_sec = 59; m_min = m_min - 1; end
                    end
                    if (cl_e) begin m_st = 0; m_min = 0; m_sec = 0; end
                    else if (sp_e || !door_closed) m_st = 2;
                    else if (t && m_min == 0 && m_sec == 0) begin m_st = 3; m_done = 1; end
                end
                2: begin
                    if (cl_e) begin m_st = 0; m_min = 0; m_sec = 0; end
                    else if (sp_e) m_st = 0;
                    else if (st_e && door_closed) begin
                        if (m_min == 0 && m_sec == 0) begin m_st = 3; m_done = 1; end
                        else m_st = 1;
                    end
                end
                default: begin
                    if (any_e || !door_closed) m_st = 0;
                    if (cl_e) begin m_min = 0; m_sec = 0; end
                end
            endcase
`ifdef MICROWAVE_DONE_BEEP_EN
            if (m_done) m_beep_left = BEEP;
            else if (m_beep_left > 0) begin
                if (any_e || !door_closed) m_beep_left = 0;
                else m_beep_left = m_beep_left - 1;
            end
`endif
            p_start = startn; p_stop = stopn; p_clear = clearn;
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clock) begin
        if (cmp_en) begin
            check("cyc_state", 16'(state), 16'(m_st));
            check("cyc_digits", {min_tens, min_ones, sec_tens, sec_ones}, m_digits());
            check("cyc_mag_on", 16'(mag_on), 16'(m_st == 1 && door_closed));
            check("cyc_done", 16'(done), 16'(m_done));
            check("cyc_beep", 16'(beep), 16'(m_beep_left > 0));
        end
    end

    // ---------------- driver tasks ----------------
    // Inputs change 2 time units after a rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic key(input logic [3:0] d);
        key_valid = 1; key_digit = d;
        tick(1);
        key_valid = 0;
    endtask

    task automatic press_start();
        startn = 0; tick(1); startn = 1; tick(1);
    endtask
    task automatic press_stop();
        stopn = 0; tick(1); stopn = 1; tick(1);
    endtask
    task automatic press_clear();
        clearn = 0; tick(1); clearn = 1; tick(1);
    endtask

    function automatic logic [15:0] digits();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        reset = 1; startn = 1; stopn = 1; clearn = 1;
        door_closed = 0; key_valid = 0; key_digit = 0;
        tick(2);
        reset = 0;
        cmp_en = 1;
        check("rst_state", 16'(state), 16'h0);
        check("rst_digits", digits(), 16'h0000);
        check("rst_done", 16'(done), 16'h0);
        check("rst_beep", 16'(beep), 16'h0);

        // Countdown 01:02 at 4 ticks per second.
        key(0); key(1); key(0); key(2);
        check("entry_0102", digits(), 16'h0102);
        door_closed = 1; tick(1);
        press_start();                         // start seen at edge E0, now E0+1
        check("start_state", 16'(state), 16'h1);
        check("start_mag", 16'(mag_on), 16'h1);
        tick(3);                               // E0+4
        check("cd_0101", digits(), 16'h0101);
        tick(8);                               // E0+12
        check("cd_0059", digits(), 16'h0059);
        tick(235);                             // E0+247
        check("pre_done", 16'(done), 16'h0);
        check("pre_done_state", 16'(state), 16'h1);
        tick(1);                               // E0+248
        check("done_pulse", 16'(done), 16'h1);
        check("done_state", 16'(state), 16'h3);
        check("done_mag", 16'(mag_on), 16'h0);
        tick(1);
        check("done_one_cycle", 16'(done), 16'h0);
        check("done_hold", 16'(state), 16'h3);
        press_clear();
        check("done_to_idle", 16'(state), 16'h0);

        // Door pause / resume at 00:05.
        key(0); key(0); key(0); key(7);
        press_start();                         // E0+1
        tick(7);                               // E0+8
        check("pause_0005", digits(), 16'h0005);
        tick(1);
        door_closed = 0;
        #1;
        check("door_mag_drop", 16'(mag_on), 16'h0);
        tick(1);
        check("door_paused", 16'(state), 16'h2);
        check("door_hold", digits(), 16'h0005);
        tick(5);
        check("door_hold2", digits(), 16'h0005);
        door_closed = 1;
        press_start();
        check("resume_state", 16'(state), 16'h1);
        tick(30);
        check("resume_done", 16'(state), 16'h3);
        door_closed = 0; tick(1);
        check("door_leaves_done", 16'(state), 16'h0);
        door_closed = 1; tick(1);

        // Door open on the final decrement, then resume into DONE.
        key(0); key(0); key(0); key(1);
        press_start();                         // E0+1
        tick(2);                               // E0+3
        door_closed = 0;
        tick(1);                               // E0+4 wrap with door open
        check("edge_paused", 16'(state), 16'h2);
        check("edge_zero", digits(), 16'h0000);
        door_closed = 1; tick(1);
        startn = 0; tick(1);
        check("edge_done", 16'(done), 16'h1);
        check("edge_done_state", 16'(state), 16'h3);
`ifdef MICROWAVE_DONE_BEEP_EN
        check("beep_on", 16'(beep), 16'h1);
`else
        check("beep_off", 16'(beep), 16'h0);
`endif
        startn = 1; tick(1);
        stopn = 0; tick(1);
        check("beep_stop", 16'(beep), 16'h0);
        check("stop_leaves_done", 16'(state), 16'h0);
        stopn = 1; tick(1);

        // Priority: clear beats start.
        key(0); key(0); key(3); key(0);
        check("entry_0030", digits(), 16'h0030);
        startn = 0; clearn = 0; tick(1);
        check("prio_state", 16'(state), 16'h0);
        check("prio_digits", digits(), 16'h0000);
        startn = 1; clearn = 1; tick(1);

        // Filtering.
        key(0); key(0); key(3); key(0);
        key(12);
        check("bad_digit", digits(), 16'h0030);
        door_closed = 0; press_start();
        check("start_door_open", 16'(state), 16'h0);
        door_closed = 1;
        press_clear(); press_start();
        check("start_zero", 16'(state), 16'h0);

        // Held start is a single event.
        key(0); key(0); key(3); key(0);
        door_closed = 0; startn = 0; tick(3);
        door_closed = 1; tick(7);
        check("held_start", 16'(state), 16'h0);
        startn = 1; tick(1);
        press_start();
        check("fresh_start", 16'(state), 16'h1);
        press_stop();
        check("stop_pause", 16'(state), 16'h2);
        press_stop();
        check("stop_idle", 16'(state), 16'h0);

        // 99:99 accepted and counts down in BCD.
        press_clear();
        key(9); key(9); key(9); key(9);
        check("entry_9999", digits(), 16'h9999);
        press_start();
        tick(3);
        check("cd_9998", digits(), 16'h9998);

        // Asynchronous reset mid-cook.
        reset = 1;
        #1;
        check("async_state", 16'(state), 16'h0);
        check("async_digits", digits(), 16'h0000);
        check("async_mag", 16'(mag_on), 16'h0);
        tick(1);
        reset = 0;
        tick(2);

        cmp_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
